serial_paralelo_rx: RTL and testbench

Receive-side deserializer for one PHY lane. Consumes the serial bit stream produced by a `paralelo_serial` lane (`phy_tx_out_0` or `phy_tx_out_1`) and runs entirely on `clk_32f`. It finds the byte boundary by hunting for the COM symbol and declares the lane active after a run of consecutive COMs. Once active, it delivers each received data byte with a one-cycle valid strobe to the downstream 8→32 converter.

---
 rtl/serial_paralelo_rx.sv | 94 +++++++++
 tb/tb_serial_paralelo_rx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_rx.sv
// Receive-side deserializer for one PHY lane.
// It shifts in one serial bit (MSB first) per clk_32f edge, hunts bit by bit
// for the COM symbol, and confirms byte alignment over LOCK_COUNT consecutive
// COMs. Once locked, it delivers each non-COM byte with a one-cycle valid strobe.
module serial_paralelo_rx #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  // com_cnt value at which the next aligned COM completes the lock
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);

  state_t     state;
  logic [7:0] sr;
  logic [7:0] sr_next;
  logic [2:0] bit_cnt;
  logic [3:0] com_cnt;
  logic       byte_done;
  logic       is_com;

  // Shift-register lookahead: the byte as it will stand after this edge
  always_comb begin
    sr_next   = {sr[6:0], data_in};
    is_com    = (sr_next == COM);
    byte_done = (bit_cnt == 3'd7);
  end

  // Alignment FSM, bit/COM counters and registered outputs
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_SEARCH;
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      com_cnt   <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr        <= sr_next;
      valid_out <= 1'b0;
      case (state)
        ST_SEARCH: begin
          // Any bit position may start a byte: compare on every edge
          bit_cnt <= 3'd0;
          com_cnt <= 4'd0;
          if (is_com) begin
            com_cnt <= 4'd1;
            state   <= ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (is_com && (com_cnt == LOCK_LAST)) begin
              state  <= ST_ACTIVE;
              active <= 1'b1;
            end else if (is_com) begin
              com_cnt <= com_cnt + 4'd1;
            end else begin
              // Misaligned or false comma: drop the byte and hunt again
              state   <= ST_SEARCH;
              com_cnt <= 4'd0;
            end
          end
        end
        ST_ACTIVE: begin
          // Locked for good; COMs are idle fill and never reach data_out
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done && !is_com) begin
            data_out  <= sr_next;
            valid_out <= 1'b1;
          end
        end
        default: begin
          state <= ST_SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: byte-level vector table plus
// hand-written reset and bit-offset sequences.
module tb_serial_paralelo_rx;

  logic       clk_32f = 1'b0;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] din;       // byte sent MSB first
    logic       act_mid;   // active during bits 0..6 of this byte
    logic       act_end;   // active after the last bit
    logic       vld_end;   // valid_out after the last bit
    logic [7:0] dout_end;  // data_out after the last bit
  } vec_t;

  vec_t       vt[28];
  logic [7:0] prev_data;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_rx #(.COM(8'hBC), .LOCK_COUNT(4)) dut (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk8({tag, "_data"}, data_out, 8'h00);
    chk1({tag, "_valid"}, valid_out, 1'b0);
    chk1({tag, "_active"}, active, 1'b0);
  endtask

  // Send one table byte; outputs sampled 1 time unit after each rising edge
  task automatic apply(input int i);
    logic mid_ok;
    mid_ok = 1'b1;
    for (int b = 7; b >= 0; b--) begin
      data_in = vt[i].din[b];
      @(posedge clk_32f);
      #1;
      if (b != 0) begin
        if (valid_out !== 1'b0 || active !== vt[i].act_mid || data_out !== prev_data)
          mid_ok = 1'b0;
      end
    end
    chk1($sformatf("mid_bits[%0d]", i), mid_ok, 1'b1);
    chk1($sformatf("active[%0d]", i), active, vt[i].act_end);
    chk1($sformatf("valid[%0d]", i), valid_out, vt[i].vld_end);
    chk8($sformatf("data[%0d]", i), data_out, vt[i].dout_end);
    prev_data = vt[i].dout_end;
  endtask

  task automatic rst_pulse(input string tag);
    reset_L = 1'b0;
    @(posedge clk_32f);
    #1;
    chk_cleared(tag);
    reset_L   = 1'b1;
    prev_data = 8'h00;
  endtask

  initial begin
    reset_L   = 1'b0;
    data_in   = 1'b0;
    prev_data = 8'h00;

    // lock after 3-bit offset, then data
    vt[0]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{8'hBC, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[4]  = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5};
    vt[5]  = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
    vt[6]  = '{8'hBC, 1'b1, 1'b1, 1'b0, 8'h3C};
    vt[7]  = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01};
    // data after a mid-ACTIVE reset, no COMs
    vt[8]  = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[9]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[10] = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h00};
    // broken lock
    vt[11] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[12] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[14] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[15] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[16] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[17] = '{8'hBC, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[18] = '{8'h7E, 1'b1, 1'b1, 1'b1, 8'h7E};
    // false commas inside 5E,00 and 17,80, then a clean lock
    vt[19] = '{8'h5E, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[20] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[21] = '{8'h17, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[22] = '{8'h80, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[23] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[24] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[25] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[26] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[27] = '{8'hBC, 1'b0, 1'b1, 1'b0, 8'h00};

    // Held in reset with random serial input
    repeat (6) begin
      data_in = 1'($urandom);
      @(posedge clk_32f);
      #1;
    end
    chk_cleared("in_reset");

    // Release; three random bits put the COMs at an arbitrary offset
    reset_L = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_in = 1'($urandom);
      @(posedge clk_32f);
      #1;
      chk1($sformatf("offset_valid%0d", k), valid_out, 1'b0);
      chk1($sformatf("offset_active%0d", k), active, 1'b0);
    end
    for (int i = 0; i <= 7; i++) apply(i);

    // Asynchronous reset in the middle of a data byte while ACTIVE
    for (int k = 0; k < 3; k++) begin
      data_in = 1'b1;
      @(posedge clk_32f);
      #1;
    end
    #3;
    reset_L = 1'b0;
    #1;
    chk_cleared("async_rst");
    @(posedge clk_32f);
    #1;
    reset_L   = 1'b1;
    prev_data = 8'h00;
    for (int i = 8; i <= 10; i++) apply(i);

    rst_pulse("rst_b");
    for (int i = 11; i <= 18; i++) apply(i);

    rst_pulse("rst_c");
    for (int i = 19; i <= 27; i++) apply(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
